// File: rtl/dcache_ctrl_if.sv
// CPU data port and backing-memory bus of the data cache controller.
// The slave modport is the controller's view, master is the CPU/memory side.
interface dcache_ctrl_if;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_ready_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_ready_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits finish in the request cycle; misses and writes go to memory.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inv_i,
    dcache_ctrl_if.slave bus,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS_RD, WR_THRU} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [31:2]         addr_q;
    logic [31:0]         wdata_q;
    logic                hit_q;

    logic [INDEX_BITS-1:0] idx, req_idx;
    logic [TAG_BITS-1:0]   tag, req_tag;
    logic                  hit;
    logic                  accept;
    logic                  hit_ev, miss_ev;
    logic                  unused_addr;

    assign idx     = bus.cpu_addr_i[INDEX_BITS+1:2];
    assign tag     = bus.cpu_addr_i[31:INDEX_BITS+2];
    assign req_idx = addr_q[INDEX_BITS+1:2];
    assign req_tag = addr_q[31:INDEX_BITS+2];
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);

    // Byte offset bits never select anything in a one-word line.
    assign unused_addr = ^bus.cpu_addr_i[1:0];

    // A request is taken only in IDLE and never in an invalidate cycle.
    assign accept = (state_q == IDLE) && !inv_i && bus.cpu_req_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && bus.cpu_we_i)  state_d = WR_THRU;
                else if (accept && !hit)     state_d = MISS_RD;
            end
            MISS_RD: if (bus.mem_ack_i) state_d = IDLE;
            WR_THRU: if (bus.mem_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic and counter events.
    always_comb begin
        bus.cpu_ready_o = 1'b0;
        bus.cpu_rdata_o = '0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        hit_ev          = 1'b0;
        miss_ev         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && !bus.cpu_we_i && hit) begin
                    bus.cpu_ready_o = 1'b1;
                    bus.cpu_rdata_o = data_q[idx];
                    hit_ev          = 1'b1;
                end
            end
            MISS_RD: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = {addr_q, 2'b00};
                if (bus.mem_ack_i) begin
                    bus.cpu_ready_o = 1'b1;
                    bus.cpu_rdata_o = bus.mem_rdata_i;
                    miss_ev         = 1'b1;
                end
            end
            WR_THRU: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = 1'b1;
                bus.mem_addr_o  = {addr_q, 2'b00};
                bus.mem_wdata_o = wdata_q;
                if (bus.mem_ack_i) begin
                    bus.cpu_ready_o = 1'b1;
                    hit_ev          = hit_q;
                    miss_ev         = !hit_q;
                end
            end
            default: ;
        endcase
    end

    // Capture the request when a memory transaction is started.
    always_ff @(posedge clk_i) begin
        if (accept && (bus.cpu_we_i || !hit)) begin
            addr_q  <= bus.cpu_addr_i[31:2];
            wdata_q <= bus.cpu_wdata_i;
            hit_q   <= hit;
        end
    end

    // Valid bits: cleared by reset or invalidate, set on a line fill.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            valid_q <= '0;
        else if (state_q == IDLE && inv_i)
            valid_q <= '0;
        else if (state_q == MISS_RD && bus.mem_ack_i)
            valid_q[req_idx] <= 1'b1;
    end

    // Tag/data arrays: fill on read miss, update on write hit.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == MISS_RD && bus.mem_ack_i) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= bus.mem_rdata_i;
        end else if (!rst_i && state_q == WR_THRU &&
                     bus.mem_ack_i && hit_q) begin
            data_q[req_idx] <= wdata_q;
        end
    end

    // Hit and miss statistics, wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit_ev)  hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (miss_ev) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a queue of expected CPU read data.
// Expected values come from the test sequence, not from the design.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inv = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic [31:0] exp_q [$];

    dcache_ctrl_if bus ();

    dcache_ctrl #(.INDEX_BITS(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .inv_i      (inv),
        .bus        (bus.slave),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed output expected none queued", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, bus.cpu_rdata_o, e);
        end
    endtask

    task automatic idle_bus();
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_hits"}, hit_cnt, exp_hits);
        chk({tag, "_miss"}, miss_cnt, exp_miss);
        chk({tag, "_req0"}, {31'd0, bus.mem_req_o}, 32'd0);
    endtask

    // Read: hit completes this cycle, miss acks on cycle n of MISS_RD.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input bit exp_hit, input int n,
                           input logic [31:0] mrd,
                           input logic [31:0] exp_rd);
        @(posedge clk); #1;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = addr;
        exp_q.push_back(exp_rd);
        #3;
        chk({tag, "_rdy0"}, {31'd0, bus.cpu_ready_o}, {31'd0, exp_hit});
        chk({tag, "_mreq0"}, {31'd0, bus.mem_req_o}, 32'd0);
        if (exp_hit) begin
            pop_chk({tag, "_hitdata"});
            exp_hits++;
        end else begin
            chk({tag, "_rd0"}, bus.cpu_rdata_o, 32'd0);
            for (int c = 1; c <= n; c++) begin
                @(posedge clk); #1;
                if (c == n) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = mrd;
                end
                #3;
                chk({tag, "_mreq"}, {31'd0, bus.mem_req_o}, 32'd1);
                chk({tag, "_mwe"}, {31'd0, bus.mem_we_o}, 32'd0);
                chk({tag, "_maddr"}, bus.mem_addr_o, {addr[31:2], 2'b00});
                chk({tag, "_rdy"}, {31'd0, bus.cpu_ready_o},
                    (c == n) ? 32'd1 : 32'd0);
                if (c == n) pop_chk({tag, "_missdata"});
            end
            exp_miss++;
        end
        @(posedge clk); #1;
        idle_bus();
        #3;
        chk_cnt(tag);
    endtask

    // Write-through: acks on cycle n of WR_THRU.
    task automatic do_write(input string tag, input logic [31:0] addr,
                            input logic [31:0] wd, input bit exp_hit,
                            input int n);
        @(posedge clk); #1;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b1;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        exp_q.push_back(32'd0);
        #3;
        chk({tag, "_rdy0"}, {31'd0, bus.cpu_ready_o}, 32'd0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == n) bus.mem_ack_i = 1'b1;
            #3;
            chk({tag, "_mreq"}, {31'd0, bus.mem_req_o}, 32'd1);
            chk({tag, "_mwe"}, {31'd0, bus.mem_we_o}, 32'd1);
            chk({tag, "_maddr"}, bus.mem_addr_o, {addr[31:2], 2'b00});
            chk({tag, "_mwdata"}, bus.mem_wdata_o, wd);
            chk({tag, "_rdy"}, {31'd0, bus.cpu_ready_o},
                (c == n) ? 32'd1 : 32'd0);
            if (c == n) pop_chk({tag, "_wrdata"});
        end
        if (exp_hit) exp_hits++;
        else         exp_miss++;
        @(posedge clk); #1;
        idle_bus();
        #3;
        chk_cnt(tag);
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("rst_rdy", {31'd0, bus.cpu_ready_o}, 32'd0);
        chk("rst_rdata", bus.cpu_rdata_o, 32'd0);
        chk("rst_mwe", {31'd0, bus.mem_we_o}, 32'd0);
        chk("rst_maddr", bus.mem_addr_o, 32'd0);
        chk("rst_mwdata", bus.mem_wdata_o, 32'd0);
        chk_cnt("rst");

        do_read("t1_miss", 32'h40, 1'b0, 3, 32'hDEADBEEF, 32'hDEADBEEF);
        do_read("t1_hit", 32'h43, 1'b1, 0, 32'h0, 32'hDEADBEEF);

        do_read("t2_conf", 32'h80, 1'b0, 1, 32'hCAFE0080, 32'hCAFE0080);
        do_read("t2_back", 32'h40, 1'b0, 2, 32'hDEADBEEF, 32'hDEADBEEF);

        do_write("t3_whit", 32'h40, 32'h12345678, 1'b1, 2);
        do_read("t3_rhit", 32'h40, 1'b1, 0, 32'h0, 32'h12345678);

        do_write("t4_wmiss", 32'h100, 32'hA5A5A5A5, 1'b0, 1);
        do_read("t4_noalloc", 32'h100, 1'b0, 1, 32'h00000055,
                32'h00000055);

        @(posedge clk); #1;
        inv            = 1'b1;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_addr_i = 32'h40;
        #3;
        chk("t5_inv_rdy", {31'd0, bus.cpu_ready_o}, 32'd0);
        chk("t5_inv_mreq", {31'd0, bus.mem_req_o}, 32'd0);
        @(posedge clk); #1;
        inv = 1'b0;
        idle_bus();
        do_read("t5_after", 32'h40, 1'b0, 1, 32'h00000077, 32'h00000077);

        @(posedge clk); #1;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_addr_i = 32'h80;
        @(posedge clk); #1;
        #3;
        chk("t6_mreq1", {31'd0, bus.mem_req_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_bus();
        exp_hits = 0;
        exp_miss = 0;
        #3;
        chk("t6_rdy", {31'd0, bus.cpu_ready_o}, 32'd0);
        chk_cnt("t6_rst");
        do_read("t6_miss", 32'h40, 1'b0, 1, 32'h0BADF00D, 32'h0BADF00D);

        chk("q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
